// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART TX round-robin scheduler.
package uart_tx_sched_pkg;
  typedef enum logic [0:0] {IDLE_SCHED, GRANT_SCHED} uart_sched_state_t;

  localparam int UART_SCHED_DEFAULT_TIMEOUT = 256;
  localparam int UART_SCHED_DEFAULT_NUM_REQ = 4;

  // Idle counter width; a disabled timeout still keeps a 1-bit counter.
  function automatic int sched_cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int c;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr_i) + k) % N;
      if (req_i[c]) begin
        gnt_o    = '0;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
        any_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Packet-atomic round-robin scheduler sharing one UART TX byte path among NUM_REQ producers.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = UART_SCHED_DEFAULT_NUM_REQ,
  parameter int TIMEOUT = UART_SCHED_DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 timeout_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = sched_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  uart_sched_state_t state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_nxt;
  logic               txv_q, txv_d, to_q, to_d;
  logic [7:0]         txd_q, txd_d, hold_data;
  logic               out_free, hold_valid, hold_last, xfer, to_hit;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign out_free   = ~txv_q | tx_ready_i;
  assign hold_valid = req_valid_i[hold_q];
  assign hold_last  = req_last_i[hold_q];
  assign hold_data  = req_data_i[{hold_q, 3'b000} +: 8];
  assign xfer       = (state_q == GRANT_SCHED) & hold_valid & out_free;
  assign cnt_nxt    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign to_hit     = (TIMEOUT != 0) && (cnt_nxt == TO_LIM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    txv_d   = txv_q & ~tx_ready_i;
    txd_d   = txd_q;
    if (xfer) begin
      txv_d = 1'b1;
      txd_d = hold_data;
    end
    case (state_q)
      IDLE_SCHED: begin
        if (pick_any) begin
          state_d = GRANT_SCHED;
          hold_d  = pick_idx;
          gnt_d   = pick_gnt;
          cnt_d   = '0;
        end
      end
      GRANT_SCHED: begin
        if (xfer) begin
          cnt_d = '0;
          if (hold_last) begin
            state_d = IDLE_SCHED;
            ptr_d   = hold_q;
            gnt_d   = '0;
          end
        end else if (!hold_valid) begin
          // Only producer silence counts; back-pressure from the FIFO does not.
          cnt_d = cnt_nxt;
          if (to_hit) begin
            state_d = IDLE_SCHED;
            ptr_d   = hold_q;
            gnt_d   = '0;
            to_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE_SCHED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_SCHED;
      ptr_q   <= IW'(NUM_REQ - 1);
      hold_q  <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= 8'h00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      to_q    <= to_d;
    end
  end

  assign req_ready_o = gnt_q & {NUM_REQ{out_free}};
  assign grant_o     = gnt_q;
  assign tx_valid_o  = txv_q;
  assign tx_data_o   = txd_q;
  assign timeout_o   = to_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: vector table, directed corner sequences, randomized run vs reference model.
module tb_uart_tx_sched;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           tx_valid, tx_ready, timeout;
  logic [7:0]     tx_data;

  uart_tx_sched #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .tx_ready_i(tx_ready), .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: holder index (-1 = nobody), rr pointer, idle count, output slot.
  int         m_hold, m_ptr, m_cnt;
  logic       m_txv, m_to;
  logic [7:0] m_txd;

  logic [8:0] pq [N][$];   // per-producer {last, byte}
  logic [N-1:0] en;
  logic [7:0] acc_q[$];
  logic [7:0] dlv_q[$];
  int         gorder[$];
  int         acc_cyc[N];
  int         to_cyc;
  int         g_first[N];
  logic [N-1:0] prev_grant;
  int         mute[N];

  typedef struct {
    logic [N-1:0] v, l;
    logic [7:0]   d0;
    logic         rdy;
    logic [N-1:0] eg, er;
    logic         ev;
    logic [7:0]   ed;
    logic         eto;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int n = 0; n < N; n++) begin
      req_valid[n]       = en[n] && (mute[n] == 0) && (pq[n].size() > 0);
      req_data[8*n +: 8] = req_valid[n] ? pq[n][0][7:0] : 8'h00;
      req_last[n]        = req_valid[n] ? pq[n][0][8] : 1'b0;
    end
  endtask

  task automatic model_adv();
    logic [N-1:0] er;
    bit acc;
    int h;
    h   = m_hold;
    er  = (h >= 0 && (!m_txv || tx_ready)) ? N'(1 << h) : '0;
    acc = (h >= 0) && er[h] && req_valid[h];
    if (acc) begin
      m_txv = 1'b1;
      m_txd = req_data[8*h +: 8];
    end else if (tx_ready) m_txv = 1'b0;
    m_to = 1'b0;
    if (h < 0) begin
      for (int k = 1; k <= N; k++)
        if (m_hold < 0 && req_valid[(m_ptr + k) % N]) m_hold = (m_ptr + k) % N;
      m_cnt = 0;
    end else if (acc) begin
      m_cnt = 0;
      if (req_last[h]) begin m_ptr = h; m_hold = -1; end
    end else if (!req_valid[h]) begin
      m_cnt++;
      if (m_cnt == TO) begin m_to = 1'b1; m_ptr = h; m_hold = -1; end
    end
  endtask

  // One clock: compare against the model, score the byte streams, advance.
  task automatic step(input bit use_q);
    int ai;
    logic [N-1:0] eg;
    if (use_q) drive();
    #1;
    eg = (m_hold >= 0) ? N'(1 << m_hold) : '0;
    chk("grant", grant, eg);
    chk("ready", req_ready, (m_hold >= 0 && (!m_txv || tx_ready)) ? eg : '0);
    chk("tx_valid", tx_valid, m_txv);
    chk("tx_data", tx_data, m_txd);
    chk("timeout", timeout, m_to);
    if (tx_valid && tx_ready) begin
      chk("dlv_pending", acc_q.size() != 0, 1);
      if (acc_q.size() != 0) chk("dlv_byte", tx_data, acc_q.pop_front());
      dlv_q.push_back(tx_data);
    end
    if (timeout && to_cyc < 0) to_cyc = cyc;
    if (grant != 0 && prev_grant == 0)
      for (int n = 0; n < N; n++) if (grant[n]) gorder.push_back(n);
    for (int n = 0; n < N; n++) if (grant[n] && g_first[n] < 0) g_first[n] = cyc;
    prev_grant = grant;
    ai = -1;
    for (int n = 0; n < N; n++) if (req_valid[n] && req_ready[n]) ai = n;
    if (ai >= 0) begin
      acc_q.push_back(req_data[8*ai +: 8]);
      acc_cyc[ai] = cyc;
    end
    model_adv();
    @(posedge clk);
    #1;
    cyc++;
    if (use_q && ai >= 0) void'(pq[ai].pop_front());
    for (int n = 0; n < N; n++) if (mute[n] > 0) mute[n]--;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1; en = '1;
    for (int n = 0; n < N; n++) begin
      pq[n].delete(); acc_cyc[n] = -1; g_first[n] = -1; mute[n] = 0;
    end
    acc_q.delete(); dlv_q.delete(); gorder.delete();
    to_cyc = -1; prev_grant = '0;
    m_hold = -1; m_ptr = N - 1; m_cnt = 0; m_txv = 1'b0; m_txd = 8'h00; m_to = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_to", timeout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add_pkt(input int n, input int len);
    for (int i = 0; i < len; i++)
      pq[n].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
  endtask

  initial begin
    // Table: v, l, d0, rdy | grant, ready, tx_valid, tx_data, timeout (requester 0 only)
    vecs.push_back('{4'h1, 4'h0, 8'h48, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{4'h1, 4'h0, 8'h48, 1'b1, 4'h1, 4'h1, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{4'h1, 4'h0, 8'h49, 1'b1, 4'h1, 4'h1, 1'b1, 8'h48, 1'b0});
    vecs.push_back('{4'h1, 4'h1, 8'h0A, 1'b1, 4'h1, 4'h1, 1'b1, 8'h49, 1'b0});
    vecs.push_back('{4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 8'h0A, 1'b0});
    vecs.push_back('{4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 8'h0A, 1'b0});
    vecs.push_back('{4'h1, 4'h1, 8'h5A, 1'b1, 4'h0, 4'h0, 1'b0, 8'h0A, 1'b0});
    vecs.push_back('{4'h1, 4'h1, 8'h5A, 1'b1, 4'h1, 4'h1, 1'b0, 8'h0A, 1'b0});
    vecs.push_back('{4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{4'h0, 4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 8'h5A, 1'b0});

    do_reset();
    foreach (vecs[i]) begin
      req_valid = vecs[i].v; req_last = vecs[i].l;
      req_data = {24'h0, vecs[i].d0}; tx_ready = vecs[i].rdy;
      #1;
      chk("vec_grant", grant, vecs[i].eg);
      chk("vec_ready", req_ready, vecs[i].er);
      chk("vec_txv", tx_valid, vecs[i].ev);
      chk("vec_txd", tx_data, vecs[i].ed);
      chk("vec_to", timeout, vecs[i].eto);
      step(0);
    end

    // Two simultaneous 3-byte packets: no interleave, req0 first.
    do_reset();
    pq[0] = '{9'h011, 9'h012, 9'h113};
    pq[1] = '{9'h021, 9'h022, 9'h123};
    repeat (16) step(1);
    chk("pkt2_count", dlv_q.size(), 6);
    if (dlv_q.size() == 6) begin
      chk("pkt2_b0", dlv_q[0], 8'h11); chk("pkt2_b2", dlv_q[2], 8'h13);
      chk("pkt2_b3", dlv_q[3], 8'h21); chk("pkt2_b5", dlv_q[5], 8'h23);
    end

    // Back-pressure for 5 cycles mid-stream.
    do_reset();
    add_pkt(0, 8);
    repeat (3) step(1);
    begin
      logic [7:0] cap;
      cap = tx_data;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step(1);
        chk("stall_data", tx_data, cap);
        chk("stall_valid", tx_valid, 1);
        chk("stall_ready", req_ready, 0);
      end
    end
    tx_ready = 1'b1;
    repeat (12) step(1);
    chk("stall_count", dlv_q.size(), 8);

    // Timeout: req2 sends 0x55 without last then goes quiet, req3 waiting.
    do_reset();
    pq[2] = '{9'h055};
    pq[3] = '{9'h177};
    repeat (30) step(1);
    chk("to_delay", to_cyc - acc_cyc[2], 17);
    chk("to_next_grant", g_first[3] - to_cyc, 1);
    chk("to_count", dlv_q.size(), 2);
    if (dlv_q.size() == 2) begin
      chk("to_b0", dlv_q[0], 8'h55);
      chk("to_b1", dlv_q[1], 8'h77);
    end

    // Asynchronous reset mid-packet of req1.
    do_reset();
    add_pkt(1, 6);
    repeat (4) step(1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_txv", tx_valid, 0);
    chk("arst_ready", req_ready, 0);
    do_reset();
    pq[0] = '{9'h101};
    pq[1] = '{9'h102};
    repeat (6) step(1);
    chk("arst_order_n", gorder.size(), 2);
    if (gorder.size() >= 1) chk("arst_first", gorder[0], 0);

    // All four streaming 1-byte packets: strict rotation.
    do_reset();
    for (int n = 0; n < N; n++) repeat (3) add_pkt(n, 1);
    repeat (40) step(1);
    chk("rot_n", gorder.size(), 12);
    foreach (gorder[i]) chk("rot_order", gorder[i], i % N);

    // Randomized traffic with gaps, long silences and back-pressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < N; n++) begin
        if (pq[n].size() < 3 && $urandom_range(0, 3) == 0) add_pkt(n, $urandom_range(1, 4));
        en[n] = ($urandom_range(0, 9) != 0);
        if (mute[n] == 0 && $urandom_range(0, 299) == 0) mute[n] = 20;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    en = '1; tx_ready = 1'b1;
    for (int n = 0; n < N; n++) mute[n] = 0;
    repeat (200) step(1);
    chk("rand_drained", acc_q.size(), 0);
    chk("rand_queues", pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
